// File: rtl/sd_wr_if.sv
// sd_wr_if: sector-write handshake between the stream writer (master) and the SD write controller
interface sd_wr_if #(parameter int DATA_W = 16);
  logic              wr_req;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_busy;
  logic              wr_en;
  modport master (output wr_req, wr_addr, wr_data, input wr_busy, wr_en);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_busy, wr_en);
endinterface

// File: rtl/sd_sector_stream_writer.sv
// sd_sector_stream_writer: packs a byte stream into ping-pong sector buffers and streams them to the SD writer
module sd_sector_stream_writer #(
  parameter int          DATA_W         = 16,
  parameter int          SECTOR_BYTES   = 512,
  parameter logic [31:0] START_ADDR     = 32'h0,
  parameter logic [31:0] END_ADDR       = 32'hFFFF,
  parameter int          IDLE_FLUSH_CYC = 50000,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        flush,
  sd_wr_if.master     wr,
  output logic [31:0] sectors_done,
  output logic [15:0] drop_cnt,
  output logic        wrapped
);
  localparam int NB    = DATA_W / 8;
  localparam int WORDS = SECTOR_BYTES / NB;
  localparam int BW    = SECTOR_BYTES > 1 ? $clog2(SECTOR_BYTES) : 1;
  localparam int WW    = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int LS    = $clog2(NB);
  localparam int IW    = $clog2(IDLE_FLUSH_CYC + 2);
  typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} state_t;
  state_t            state, state_n;
  logic [DATA_W-1:0] mem [2][WORDS];
  logic [1:0]        full;
  logic              fbuf, rbuf, pad;
  logic [BW-1:0]     bidx;
  logic [WW-1:0]     widx;
  logic [IW-1:0]     idle_cnt;
  logic              idle_hit, pad_now, we, last_byte;
  logic [7:0]        wbyte;
  assign idle_hit  = IDLE_FLUSH_CYC != 0 && idle_cnt == IW'(IDLE_FLUSH_CYC);
  assign pad_now   = pad | ((flush | idle_hit) & (bidx != '0));
  // a real byte always wins the write slot; padding simply resumes next cycle
  assign we        = ~full[fbuf] & (in_valid | pad_now);
  assign wbyte     = in_valid ? in_data : PAD_BYTE;
  assign last_byte = we & (bidx == BW'(SECTOR_BYTES - 1));
  assign wr.wr_req = state == REQ;
  always_ff @(posedge sys_clk)
    if (we) mem[fbuf][WW'(bidx >> LS)][DATA_W - 8 - 8 * int'(bidx % BW'(NB)) +: 8] <= wbyte;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = full[rbuf] ? REQ : IDLE;
      REQ:     state_n = wr.wr_busy ? STREAM : REQ;
      STREAM:  state_n = wr.wr_busy ? STREAM : DONE;
      default: state_n = full[~rbuf] ? REQ : IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state        <= IDLE;
      full         <= '0;
      fbuf         <= 1'b0;
      rbuf         <= 1'b0;
      pad          <= 1'b0;
      bidx         <= '0;
      widx         <= '0;
      idle_cnt     <= '0;
      wr.wr_data   <= '0;
      wr.wr_addr   <= START_ADDR;
      sectors_done <= '0;
      drop_cnt     <= '0;
      wrapped      <= 1'b0;
    end else begin
      state    <= state_n;
      idle_cnt <= in_valid ? '0 : idle_cnt + IW'(idle_cnt != IW'(IDLE_FLUSH_CYC));
      if (in_valid & full[fbuf]) drop_cnt <= drop_cnt + 16'(drop_cnt != '1);
      if (we) begin
        bidx <= last_byte ? '0 : bidx + 1'b1;
        pad  <= pad_now & ~last_byte;
      end
      if (last_byte) begin
        full[fbuf] <= 1'b1;
        fbuf       <= ~fbuf;
      end
      // entering REQ from DONE serves the other buffer, since rbuf toggles on this edge
      if (state_n == REQ && state != REQ) begin
        widx       <= '0;
        wr.wr_data <= mem[state == DONE ? ~rbuf : rbuf][0];
      end
      if (state == STREAM && wr.wr_en && widx != WW'(WORDS - 1)) begin
        widx       <= widx + 1'b1;
        wr.wr_data <= mem[rbuf][widx + 1'b1];
      end
      if (state == DONE) begin
        full[rbuf]   <= 1'b0;
        rbuf         <= ~rbuf;
        sectors_done <= sectors_done + 32'd1;
        wrapped      <= wrapped | (wr.wr_addr == END_ADDR);
        wr.wr_addr   <= wr.wr_addr == END_ADDR ? START_ADDR : wr.wr_addr + 32'd1;
      end
    end
endmodule

// File: tb/tb_sd_sector_stream_writer.sv
// tb_sd_sector_stream_writer: directed + random byte streams against a sector-chopping reference model
module tb_sd_sector_stream_writer;
  localparam int          SB    = 512;
  localparam int          WORDS = 256;
  localparam logic [31:0] SA    = 32'd5;
  localparam logic [31:0] EA    = 32'd6;
  localparam logic [7:0]  PAD   = 8'hA5;
  logic        sys_clk = 0, sys_rst_n = 1, in_valid = 0, flush = 0;
  logic [7:0]  in_data = 0;
  logic [31:0] sectors_done;
  logic [15:0] drop_cnt;
  logic        wrapped;
  int          total = 0, bad = 0, req_rise = 0;
  bit          hold = 0, req_prev = 0;
  logic [31:0] cap_addr[$];
  logic [15:0] cap_words[$];
  byte unsigned got[SB];
  byte unsigned exp_q[$];
  byte unsigned stream[$];
  sd_wr_if #(.DATA_W(16)) bus();
  sd_sector_stream_writer #(.DATA_W(16), .SECTOR_BYTES(SB), .START_ADDR(SA), .END_ADDR(EA),
                            .IDLE_FLUSH_CYC(40), .PAD_BYTE(PAD)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .wr(bus), .sectors_done(sectors_done), .drop_cnt(drop_cnt), .wrapped(wrapped));
  always #10 sys_clk = ~sys_clk;
  always @(negedge sys_clk) begin
    if (bus.wr_req === 1'b1 && !req_prev) req_rise++;
    req_prev = bus.wr_req === 1'b1;
  end
  // SD controller model: grants after a random delay, pulls every word with random wr_en gaps
  initial begin
    bus.wr_busy = 0;
    bus.wr_en = 0;
    forever begin
      @(negedge sys_clk);
      if (bus.wr_req === 1'b1) begin
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        bus.wr_busy = 1;
        if (hold) begin
          while (hold) @(negedge sys_clk);
        end else begin
          cap_addr.push_back(bus.wr_addr);
          for (int i = 0; i < WORDS; i++) begin
            @(negedge sys_clk);
            if ($urandom_range(0, 3) == 0) begin
              bus.wr_en = 0;
              @(negedge sys_clk);
            end
            cap_words.push_back(bus.wr_data);
            bus.wr_en = 1;
          end
          @(negedge sys_clk);
          bus.wr_en = 0;
        end
        bus.wr_busy = 0;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1;
    in_data = b;
    @(negedge sys_clk);
    in_valid = 0;
    repeat (gap) @(negedge sys_clk);
  endtask
  task automatic wait_sectors(input logic [31:0] n, input string tag);
    int t = 0;
    while (sectors_done !== n && t < 20000) begin
      @(negedge sys_clk);
      t++;
    end
    chk(tag, sectors_done, n);
  endtask
  task automatic pull(input logic [31:0] ea, input string tag);
    logic [15:0] w;
    bit ok;
    ok = cap_addr.size() > 0 && cap_words.size() >= WORDS;
    chk({tag, "_avail"}, 32'(ok), 1);
    for (int i = 0; i < SB; i++) got[i] = 0;
    if (ok) begin
      chk({tag, "_addr"}, cap_addr.pop_front(), ea);
      for (int i = 0; i < WORDS; i++) begin
        w = cap_words.pop_front();
        got[2*i] = w[15:8];
        got[2*i+1] = w[7:0];
      end
    end
  endtask
  task automatic next_exp();
    exp_q = {};
    for (int i = 0; i < SB; i++) exp_q.push_back(stream.size() > 0 ? stream.pop_front() : PAD);
  endtask
  task automatic cmp_exp(input string tag);
    for (int i = 0; i < SB; i++) chk($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
  endtask
  initial begin
    logic [7:0] b;
    int r0, nrand;
    byte unsigned kept[$];
    #5 sys_rst_n = 0;
    repeat (3) @(negedge sys_clk);
    chk("rst_wr_req", bus.wr_req, 0);
    chk("rst_wr_addr", bus.wr_addr, SA);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_sectors", sectors_done, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_wrapped", wrapped, 0);
    sys_rst_n = 1;
    @(negedge sys_clk);
    for (int i = 0; i < SB; i++) begin
      stream.push_back(8'(i));
      send(8'(i), i == SB - 1 ? 0 : int'($urandom_range(0, 2)));
    end
    chk("lat_cyc1", bus.wr_req, 0);
    @(negedge sys_clk);
    chk("lat_cyc2", bus.wr_req, 1);
    wait_sectors(1, "t1_done");
    pull(SA, "t1");
    next_exp();
    cmp_exp("t1");
    chk("t1_wrapped", wrapped, 0);
    chk("t1_next_addr", bus.wr_addr, SA + 1);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      send(b, 1);
    end
    wait_sectors(2, "t2_done");
    pull(EA, "t2");
    next_exp();
    cmp_exp("t2");
    chk("t2_wrapped", wrapped, 1);
    chk("t2_addr_wrap", bus.wr_addr, SA);
    for (int i = 0; i < 7; i++) begin
      b = 8'($urandom_range(1, 127));
      stream.push_back(b);
      send(b, 0);
    end
    flush = 1;
    @(negedge sys_clk);
    flush = 0;
    repeat (2) @(negedge sys_clk);
    b = 8'($urandom_range(1, 127));
    stream.push_back(b);
    send(b, 1);
    b = 8'($urandom_range(1, 127));
    stream.push_back(b);
    send(b, 0);
    wait_sectors(3, "t3_done");
    pull(SA, "t3");
    for (int i = 0; i < SB; i++) if (got[i] != PAD) kept.push_back(got[i]);
    chk("t3_real_count", kept.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t3_order%0d", i), i < kept.size() ? kept[i] : 8'h00, stream[i]);
    chk("t3_tail_pad", got[SB-1], PAD);
    stream = {};
    r0 = req_rise;
    flush = 1;
    @(negedge sys_clk);
    flush = 0;
    repeat (60) @(negedge sys_clk);
    chk("t4_no_req", req_rise, r0);
    chk("t4_sectors", sectors_done, 3);
    hold = 1;
    r0 = req_rise;
    for (int i = 0; i < 1100; i++) send(8'($urandom), 0);
    repeat (50) @(negedge sys_clk);
    chk("t5_drop", drop_cnt, 76);
    chk("t5_req_once", req_rise, r0 + 1);
    chk("t5_req_low", bus.wr_req, 0);
    chk("t5_sectors", sectors_done, 3);
    sys_rst_n = 0;
    #3;
    chk("t6_wr_req", bus.wr_req, 0);
    chk("t6_wr_addr", bus.wr_addr, SA);
    chk("t6_sectors", sectors_done, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_wrapped", wrapped, 0);
    @(negedge sys_clk);
    hold = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1;
    r0 = req_rise;
    repeat (60) @(negedge sys_clk);
    chk("t6_no_stale_req", req_rise, r0);
    nrand = 2 * SB + int'($urandom_range(1, SB - 1));
    for (int i = 0; i < nrand; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      send(b, i == nrand - 1 ? 0 : int'($urandom_range(0, 2)));
    end
    flush = 1;
    @(negedge sys_clk);
    flush = 0;
    wait_sectors(3, "t7_done");
    pull(SA, "t7s0");
    next_exp();
    cmp_exp("t7s0");
    pull(EA, "t7s1");
    next_exp();
    cmp_exp("t7s1");
    pull(SA, "t7s2");
    next_exp();
    cmp_exp("t7s2");
    chk("t7_drop", drop_cnt, 0);
    chk("t7_wrapped", wrapped, 1);
    chk("t7_req_count", req_rise, r0 + 3);
    chk("t7_leftover", cap_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
